// File: rtl/bus_xbar_ctrl_if.sv
// Bus bundle for bus_xbar_ctrl: master request/response side plus shared slave side.
// Modport slave is the controller's view; modport master is the surrounding system.
interface bus_xbar_ctrl_if #(
    parameter int NSLV   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MW = DATA_W / 8;

    logic                   m_req;
    logic                   m_ready;
    logic [ADDR_W-1:0]      m_addr;
    logic [MW-1:0]          m_wmask;
    logic [DATA_W-1:0]      m_wdata;
    logic                   m_ack;
    logic                   m_err;
    logic [DATA_W-1:0]      m_rdata;
    logic [NSLV-1:0]        s_sel;
    logic [ADDR_W-1:0]      s_addr;
    logic [MW-1:0]          s_wmask;
    logic [DATA_W-1:0]      s_wdata;
    logic [NSLV-1:0]        s_ack;
    logic [NSLV*DATA_W-1:0] s_rdata;

    modport slave (
        input  m_req, m_addr, m_wmask, m_wdata, s_ack, s_rdata,
        output m_ready, m_ack, m_err, m_rdata,
        output s_sel, s_addr, s_wmask, s_wdata
    );

    modport master (
        output m_req, m_addr, m_wmask, m_wdata, s_ack, s_rdata,
        input  m_ready, m_ack, m_err, m_rdata,
        input  s_sel, s_addr, s_wmask, s_wdata
    );
endinterface

// File: rtl/bus_xbar_ctrl.sv
// Single-master to NSLV-slave bus controller with top-nibble address decode.
// Define BUS_XBAR_TIMEOUT_EN to enable the ACCESS-phase bus-error timeout.
module bus_xbar_ctrl #(
    parameter int NSLV    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    bus_xbar_ctrl_if.slave  bus
);
    localparam int MW = DATA_W / 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    if (NSLV < 1 || NSLV > 15 || TIMEOUT < 1 || TIMEOUT > 255 ||
        ADDR_W < 8 || (DATA_W % 8) != 0) begin : g_bad_cfg
        $error("bus_xbar_ctrl: illegal parameter set");
    end

    logic [1:0]        state_q, state_d;
    logic [NSLV-1:0]   sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MW-1:0]     wmask_q, wmask_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [3:0]        idx;
    logic [NSLV-1:0]   dec_sel;
    logic [DATA_W-1:0] slv_rdata;
    logic              sel_ack;
    logic              tmo;

    assign idx = bus.m_addr[ADDR_W-1 -: 4];

    // Index 0 and indices above NSLV are decode misses.
    always_comb begin
        dec_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            dec_sel[i] = (idx == 4'(i + 1));
        end
    end

    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q[i]) begin
                slv_rdata = slv_rdata | bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_ack = |(bus.s_ack & sel_q);

`ifdef BUS_XBAR_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    assign tmo = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == ACCESS && !sel_ack && !tmo) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.m_req) begin
                    addr_d  = bus.m_addr;
                    wmask_d = bus.m_wmask;
                    wdata_d = bus.m_wdata;
                    if (|dec_sel) begin
                        sel_d   = dec_sel;
                        state_d = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                // A real ack takes priority over an expiring timeout.
                if (sel_ack) begin
                    err_d   = 1'b0;
                    rdata_d = (wmask_q == '0) ? slv_rdata : '0;
                    sel_d   = '0;
                    state_d = RESP;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    sel_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.m_ready = (state_q == IDLE);
    assign bus.m_ack   = (state_q == RESP);
    assign bus.m_err   = (state_q == RESP) && err_q;
    assign bus.m_rdata = rdata_q;
    assign bus.s_sel   = sel_q;
    assign bus.s_addr  = addr_q;
    assign bus.s_wmask = wmask_q;
    assign bus.s_wdata = wdata_q;
endmodule

// File: doc/bus_xbar_ctrl.md
BUS_XBAR_CTRL -- requirements
Module: bus_xbar_ctrl

Interface
REQ-001 Parameter: NSLV, 4, number of slave ports (legal 1..15).
REQ-002 Parameter: ADDR_W, 32, address width (>= 8).
REQ-003 Parameter: DATA_W, 32, data width (multiple of 8); mask width MW = DATA_W/8.
REQ-004 Parameter: TIMEOUT, 16, ACCESS cycles allowed before bus error (legal 1..255).
REQ-005 One clock; reset is synchronous and active-high; ports clk and rst.
REQ-006 Port: clk  in  1  rising-edge clock.
REQ-007 Port: rst  in  1  synchronous active-high reset.
REQ-008 Port: m_req  in  1  master request; sampled only while m_ready=1.
REQ-009 Port: m_ready  out  1  controller idle and able to accept a request.
REQ-010 Port: m_addr  in  ADDR_W  request address.
REQ-011 Port: m_wmask  in  MW  byte write mask; all-zero = read.
REQ-012 Port: m_wdata  in  DATA_W  write data.
REQ-013 Port: m_ack  out  1  one-cycle response strobe.
REQ-014 Port: m_err  out  1  response is an error; valid with m_ack.
REQ-015 Port: m_rdata  out  DATA_W  read data; valid with m_ack, held until next response.
REQ-016 Port: s_sel  out  NSLV  one-hot slave select.
REQ-017 Port: s_addr / s_wmask / s_wdata  out  ADDR_W / MW / DATA_W  latched request, shared by all slaves.
REQ-018 Port: s_ack  in  NSLV  per-slave completion.
REQ-019 Port: s_rdata  in  NSLV*DATA_W  per-slave read data; slave i in bits [i*DATA_W +: DATA_W].

Function
REQ-020 Decode: idx = m_addr[ADDR_W-1:ADDR_W-4]; hit iff 1 <= idx <= NSLV, selecting slave idx-1.
REQ-021 FSM states IDLE, ACCESS, RESP; m_ready=1 only in IDLE.
REQ-022 IDLE, m_req=1: latch addr/wmask/wdata into s_* outputs; hit -> ACCESS with s_sel one-hot; miss -> RESP, err=1, rdata=0.
REQ-023 ACCESS: s_sel and s_* stay stable; s_ack of the selected slave -> RESP, err=0, s_sel cleared on the transition.
REQ-024 On that ack, read (wmask=0) captures the selected slave's s_rdata slice; write returns rdata=0.
REQ-025 s_ack bits of non-selected slaves are ignored in all states.
REQ-026 RESP: m_ack=1 for exactly one cycle, then IDLE.
REQ-027 Latency: req accepted at edge T, slave acks in first ACCESS cycle -> m_ack high in cycle T+2; decode miss -> m_ack in cycle T+1.
REQ-028 m_req outside IDLE is ignored; no queuing; back-to-back requests give one request per 3 cycles minimum.
REQ-029 m_err=0 and m_ack=0 whenever not in RESP; m_rdata changes only on entering RESP.

Reset
REQ-030 rst=1 at a clock edge -> IDLE; m_ready=1, m_ack=0, m_err=0, m_rdata=0, s_sel=0, s_addr=0, s_wmask=0, s_wdata=0, timeout counter=0.
REQ-031 Reset during ACCESS or RESP aborts the transaction; no m_ack is produced for it.

Configuration
REQ-032 Macro BUS_XBAR_TIMEOUT_EN defined: counter counts ACCESS cycles; TIMEOUT cycles without selected ack -> RESP with err=1, rdata=0, s_sel cleared.
REQ-033 Ack and timeout in the same cycle: ack wins, err=0.
REQ-034 Macro undefined: no counter; ACCESS waits indefinitely for s_ack; TIMEOUT unused.

Verification
REQ-035 Write: addr=0x1000_0000, wmask=4'b0011, wdata=0xFFFF_FFFF, slave0 acks immediately -> s_sel=0001, s_wmask=0011 during ACCESS, m_ack two cycles after acceptance, err=0, rdata=0.
REQ-036 Read: addr=0x3000_0004, wmask=0, slave2 rdata=0xDEAD_BEEF, ack after 3 wait cycles -> s_sel=0100, m_rdata=0xDEAD_BEEF, err=0.
REQ-037 Decode miss: addr=0x0000_0010 and addr=0x5000_0000 (NSLV=4) -> s_sel stays 0, m_ack one cycle after acceptance, err=1, rdata=0.
REQ-038 Timeout (macro on, TIMEOUT=16): slave1 never acks -> m_ack with err=1 after 16 ACCESS cycles; stray s_ack[3] during ACCESS ignored.
REQ-039 Reset mid-ACCESS: rst=1 for one cycle while s_sel=0010 -> next cycle m_ready=1, s_sel=0, no m_ack; next request completes normally.
REQ-040 m_req held high through ACCESS/RESP -> exactly one transaction per IDLE acceptance.
